// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage.
// Issues sequential fetch PCs to an instruction memory under a credit limit
// (in-flight fetches plus queued entries never exceed DEPTH), buffers the
// in-order responses together with PC and PC+4 in a small circular queue, and
// presents the queue head to decode through a valid/ready handshake.
// A redirect reloads both PCs, empties the queue and marks every fetch that is
// still in flight so that its response is discarded when it arrives.

module if_prefetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
   parameter int              DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect_valid,
   input  logic [XLEN-1:0]            redirect_pc,
   output logic                       imem_req_valid,
   input  logic                       imem_req_ready,
   output logic [XLEN-1:0]            imem_req_addr,
   input  logic                       imem_rsp_valid,
   input  logic [31:0]                imem_rsp_instr,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_pc_plus4,
   output logic [31:0]                out_instr,
   output logic [$clog2(DEPTH+1)-1:0] out_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [CW:0]     DEPTH_EXT = (CW + 1)'(DEPTH);
   localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [PW-1:0]   PTR_ZERO  = {PW{1'b0}};
   localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   // Sequential word address; wraps naturally modulo 2^XLEN.
   function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

   // Fetch stream state
   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] resp_pc_r;
   logic [CW-1:0]   outstanding_r;
   logic [CW-1:0]   drop_r;

   // Prefetch queue state
   logic [CW-1:0]   count_r;
   logic [PW-1:0]   head_r;
   logic [PW-1:0]   tail_r;
   logic [XLEN-1:0] pc_mem_r    [DEPTH];
   logic [XLEN-1:0] pc4_mem_r   [DEPTH];
   logic [31:0]     instr_mem_r [DEPTH];

   // Combinational control
   logic [CW:0]     credit_sum_s;
   logic            credit_ok_s;
   logic            req_valid_s;
   logic            req_fire_s;
   logic            push_s;
   logic            pop_s;
   logic [XLEN-1:0] redirect_pc_s;

   // Credit check, handshakes and push/pop qualification for this cycle.
   always_comb begin
      credit_sum_s  = {1'b0, outstanding_r} + {1'b0, count_r};
      credit_ok_s   = (credit_sum_s < DEPTH_EXT);
      redirect_pc_s = redirect_pc & ALIGN_MASK;

      if (reset || redirect_valid) begin
         req_valid_s = 1'b0;
      end else begin
         req_valid_s = credit_ok_s;
      end

      req_fire_s = req_valid_s && imem_req_ready;

      // A response is kept only when nothing is marked for dropping and no
      // redirect is flushing the stream in this same cycle.
      if (!reset && !redirect_valid && imem_rsp_valid && (drop_r == CNT_ZERO)) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end

      if (!reset && !redirect_valid && (count_r != CNT_ZERO) && out_ready) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = fetch_pc_r;
   assign out_valid      = (count_r != CNT_ZERO);
   assign out_pc         = pc_mem_r[head_r];
   assign out_pc_plus4   = pc4_mem_r[head_r];
   assign out_instr      = instr_mem_r[head_r];
   assign out_count      = count_r;

   // Fetch PCs, credit/drop counters and queue pointers; reset beats redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_r    <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         outstanding_r <= CNT_ZERO;
         drop_r        <= CNT_ZERO;
         count_r       <= CNT_ZERO;
         head_r        <= PTR_ZERO;
         tail_r        <= PTR_ZERO;
      end else if (redirect_valid) begin
         fetch_pc_r <= redirect_pc_s;
         resp_pc_r  <= redirect_pc_s;
         count_r    <= CNT_ZERO;
         head_r     <= PTR_ZERO;
         tail_r     <= PTR_ZERO;
         // No request issues this cycle, so whatever is still in flight
         // afterwards is exactly what has to be dropped.
         if (imem_rsp_valid) begin
            outstanding_r <= outstanding_r - CNT_ONE;
            drop_r        <= outstanding_r - CNT_ONE;
         end else begin
            outstanding_r <= outstanding_r;
            drop_r        <= outstanding_r;
         end
      end else begin
         if (req_fire_s) begin
            fetch_pc_r <= pc_inc(fetch_pc_r);
         end

         case ({req_fire_s, imem_rsp_valid})
            2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
            2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
            default: outstanding_r <= outstanding_r;
         endcase

         if (imem_rsp_valid && (drop_r != CNT_ZERO)) begin
            drop_r <= drop_r - CNT_ONE;
         end

         if (push_s) begin
            tail_r    <= tail_r + PTR_ONE;
            resp_pc_r <= pc_inc(resp_pc_r);
         end

         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end

         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Queue storage: write PC, PC+4 and instruction at the tail on push.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[tail_r]    <= resp_pc_r;
         pc4_mem_r[tail_r]   <= pc_inc(resp_pc_r);
         instr_mem_r[tail_r] <= imem_rsp_instr;
      end
   end

   if_prefetch_stage_chk #(
      .DEPTH (DEPTH)
   ) u_chk (
      .clk            (clk),
      .reset          (reset),
      .imem_rsp_valid (imem_rsp_valid),
      .outstanding    (outstanding_r),
      .push           (push_s),
      .count          (count_r)
   );

endmodule

// Protocol checks on the memory response channel and the prefetch queue.
module if_prefetch_stage_chk #(
   parameter int DEPTH = 4
) (
   input logic                       clk,
   input logic                       reset,
   input logic                       imem_rsp_valid,
   input logic [$clog2(DEPTH+1)-1:0] outstanding,
   input logic                       push,
   input logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   a_rsp_has_request : assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> (outstanding != CNT_ZERO));

   a_push_not_full : assert property (@(posedge clk) disable iff (reset)
      push |-> (count != CNT_FULL));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed testbench for if_prefetch_stage (XLEN=32, RESET_PC=0, DEPTH=4).
// A small in-order memory responder returns ~addr as the instruction after a
// configurable latency; expected values are hand-computed constants.

module tb_if_prefetch_stage;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
   logic [31:0] out_instr;
   logic [2:0]  out_count;

   int total;
   int bad;
   int cyc;
   int lat;
   int nfire;
   logic [31:0] pq_addr[$];
   int          pq_due[$];

   if_prefetch_stage #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .DEPTH    (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_instr (imem_rsp_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4),
      .out_instr      (out_instr),
      .out_count      (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Record this cycle's handshakes, advance one clock, then drive the next response.
   task automatic tick();
      #1;
      if (imem_req_valid && imem_req_ready) begin
         pq_addr.push_back(imem_req_addr);
         pq_due.push_back(cyc + lat);
         nfire = nfire + 1;
      end
      if (imem_rsp_valid && (pq_addr.size() > 0)) begin
         void'(pq_addr.pop_front());
         void'(pq_due.pop_front());
      end
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if ((pq_addr.size() > 0) && (pq_due[0] <= cyc)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_instr = ~pq_addr[0];
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_instr = 32'h0000_0000;
      end
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = 32'h0000_0000;
      pq_addr.delete();
      pq_due.delete();
      tick();
      tick();
      reset = 1'b0;
      nfire = 0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      lat   = 1;
      nfire = 0;
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0000_0000;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_instr = 32'h0000_0000;
      out_ready      = 1'b0;

      // Reset state
      tick();
      tick();
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_count", 32'(out_count), 32'd0);
      check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("rst_req_addr", imem_req_addr, 32'h0000_0000);

      // Streaming, latency 1, decode always ready
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b1;
      #1;
      check_eq("s_c0_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("s_c0_addr", imem_req_addr, 32'h0000_0000);
      check_eq("s_c0_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("s_c1_addr", imem_req_addr, 32'h0000_0004);
      check_eq("s_c1_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("s_c2_out_valid", 32'(out_valid), 32'd1);
      check_eq("s_c2_out_pc", out_pc, 32'h0000_0000);
      check_eq("s_c2_out_pc4", out_pc_plus4, 32'h0000_0004);
      check_eq("s_c2_out_instr", out_instr, 32'hFFFF_FFFF);
      check_eq("s_c2_addr", imem_req_addr, 32'h0000_0008);
      tick(); #1;
      check_eq("s_c3_out_pc", out_pc, 32'h0000_0004);
      check_eq("s_c3_out_instr", out_instr, 32'hFFFF_FFFB);
      check_eq("s_c3_out_count", 32'(out_count), 32'd1);
      tick(); #1;
      check_eq("s_c4_out_pc", out_pc, 32'h0000_0008);

      // Backpressure: queue fills to DEPTH, issue stalls until first pop
      do_reset();
      lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         tick();
      end
      #1;
      check_eq("bp_c4_req_valid", 32'(imem_req_valid), 32'd0);
      tick(); #1;
      check_eq("bp_c5_count", 32'(out_count), 32'd4);
      check_eq("bp_c5_req_valid", 32'(imem_req_valid), 32'd0);
      check_eq("bp_c5_nfire", 32'(nfire), 32'd4);
      check_eq("bp_c5_out_pc", out_pc, 32'h0000_0000);
      out_ready = 1'b1;
      #1;
      check_eq("bp_c5_req_valid_ready", 32'(imem_req_valid), 32'd0);
      tick(); #1;
      check_eq("bp_c6_count", 32'(out_count), 32'd3);
      check_eq("bp_c6_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("bp_c6_addr", imem_req_addr, 32'h0000_0010);
      check_eq("bp_c6_out_pc", out_pc, 32'h0000_0004);

      // Redirect with 3 in flight at latency 3 (low address bits ignored)
      do_reset();
      lat = 3; imem_req_ready = 1'b1; out_ready = 1'b1;
      #1;
      tick(); tick(); tick();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0107;
      #1;
      check_eq("rd_c3_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("rd_c4_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("rd_c4_addr", imem_req_addr, 32'h0000_0104);
      check_eq("rd_c4_count", 32'(out_count), 32'd0);
      tick(); #1;
      check_eq("rd_c5_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("rd_c6_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("rd_c7_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("rd_c8_out_valid", 32'(out_valid), 32'd1);
      check_eq("rd_c8_out_pc", out_pc, 32'h0000_0104);
      check_eq("rd_c8_out_pc4", out_pc_plus4, 32'h0000_0108);
      check_eq("rd_c8_out_instr", out_instr, 32'hFFFF_FEFB);

      // Redirect coinciding with a response, a pop and imem_req_ready
      do_reset();
      lat = 2; imem_req_ready = 1'b1; out_ready = 1'b1;
      #1;
      tick(); tick(); tick();
      #1;
      check_eq("rc_c3_out_valid", 32'(out_valid), 32'd1);
      check_eq("rc_c3_out_pc", out_pc, 32'h0000_0000);
      check_eq("rc_c3_rsp_present", 32'(imem_rsp_valid), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      #1;
      check_eq("rc_c3_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check_eq("rc_c4_count", 32'(out_count), 32'd0);
      check_eq("rc_c4_out_valid", 32'(out_valid), 32'd0);
      check_eq("rc_c4_addr", imem_req_addr, 32'h0000_0200);
      tick(); #1;
      check_eq("rc_c5_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("rc_c6_out_valid", 32'(out_valid), 32'd0);
      tick(); #1;
      check_eq("rc_c7_out_valid", 32'(out_valid), 32'd1);
      check_eq("rc_c7_out_pc", out_pc, 32'h0000_0200);
      check_eq("rc_c7_out_instr", out_instr, 32'hFFFF_FDFF);

      // PC wrap at the top of the address space
      do_reset();
      lat = 1; imem_req_ready = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      #1;
      check_eq("wr_c0_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect_valid = 1'b0; imem_req_ready = 1'b1;
      #1;
      check_eq("wr_c1_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("wr_c1_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick(); #1;
      check_eq("wr_c2_addr", imem_req_addr, 32'h0000_0000);
      tick(); #1;
      check_eq("wr_c3_out_valid", 32'(out_valid), 32'd1);
      check_eq("wr_c3_out_pc", out_pc, 32'hFFFF_FFFC);
      check_eq("wr_c3_out_pc4", out_pc_plus4, 32'h0000_0000);
      check_eq("wr_c3_out_instr", out_instr, 32'h0000_0003);

      // Reset mid-stream together with a redirect: reset wins
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      imem_rsp_valid = 1'b0; imem_rsp_instr = 32'h0000_0000;
      pq_addr.delete();
      pq_due.delete();
      #1;
      check_eq("rr_c0_req_valid", 32'(imem_req_valid), 32'd0);
      tick(); #1;
      check_eq("rr_c1_addr", imem_req_addr, 32'h0000_0000);
      check_eq("rr_c1_out_valid", 32'(out_valid), 32'd0);
      check_eq("rr_c1_count", 32'(out_count), 32'd0);
      check_eq("rr_c1_req_valid", 32'(imem_req_valid), 32'd0);
      reset = 1'b0; redirect_valid = 1'b0;
      #1;
      check_eq("rr_c1_rel_req_valid", 32'(imem_req_valid), 32'd1);
      check_eq("rr_c1_rel_addr", imem_req_addr, 32'h0000_0000);
      tick(); tick(); #1;
      check_eq("rr_c3_out_valid", 32'(out_valid), 32'd1);
      check_eq("rr_c3_out_pc", out_pc, 32'h0000_0000);
      check_eq("rr_c3_out_instr", out_instr, 32'hFFFF_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
- Parametrised instruction-fetch stage. Generates sequential fetch PCs and issues them to an instruction memory with a valid/ready request channel and a variable-latency, in-order response channel.
- Buffers returned instructions with their PC and PC+4 in a DEPTH-entry prefetch queue that feeds the IF/ID register through a valid/ready handshake.
- Supports redirect (branch/jump/trap) with queue flush and in-flight response squashing.

Parameters:
XLEN, 32, PC/address width (instruction width fixed at 32)
RESET_PC, 0, fetch PC after reset (XLEN bits, 4-byte aligned)
DEPTH, 4, prefetch queue entries and max (queued + in-flight) fetches; power of 2, >=2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
redirect_valid  in  1  redirect fetch stream this cycle
redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  instruction response valid (in order, no backpressure)
imem_rsp_instr  in  32  returned instruction
out_valid  out  1  queue head valid
out_ready  in  1  decode/IF-ID accepts head
out_pc  out  XLEN  head PC
out_pc_plus4  out  XLEN  head PC + 4 (mod 2^XLEN)
out_instr  out  32  head instruction
out_count  out  $clog2(DEPTH+1)  queue occupancy

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-high, sampled on posedge clk.
- State: fetch_pc, resp_pc, outstanding counter, drop counter, queue (head/tail pointers, count).
- Reset values: fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop=0, queue empty.
  - Outputs under reset: out_valid=0, out_count=0, imem_req_valid=0.
  - Reset overrides a concurrent redirect.
  - Reset mid-operation drops all queue contents; responses for requests issued before reset must not arrive after reset (system guarantee).
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (outstanding + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps mod 2^XLEN) and outstanding increments.
  - Once asserted, valid and addr hold until accepted or redirect.
- Response:
  - Arrives >=1 cycle after acceptance; rsp_valid with outstanding=0 is illegal (assertion).
  - Each response decrements outstanding.
  - If drop>0: response discarded, drop decrements.
  - Otherwise push {resp_pc, instr} at the tail and resp_pc += 4.
  - The credit rule guarantees the queue is never full on push; push-on-full is an assertion failure.
- Output:
  - out_valid = (count != 0); out_* are driven combinationally from the head entry.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - No bypass: a response becomes visible at the output 1 cycle after arrival.
  - Pointers wrap modulo DEPTH.
  - Minimum latency from request acceptance to out_valid is 2 cycles.
- Redirect (redirect_valid=1, highest priority after reset):
  - No request is issued that cycle; queue count resets to 0 (any pop that cycle is discarded).
  - fetch_pc and resp_pc load {redirect_pc[XLEN-1:2],2'b00}.
  - drop = outstanding - (imem_rsp_valid?1:0) + (drop>0 && imem_rsp_valid ? 0 : 0). Equivalently, all requests still in flight after this cycle will be dropped. A response arriving in the redirect cycle is itself discarded.
  - outstanding updates normally.
  - Requests resume the next cycle if credit allows: outstanding + 0 < DEPTH.
- Back-to-back redirects: each one reloads the PCs and recomputes drop from the current outstanding count. Net effect: only responses to requests issued after the last redirect are ever enqueued.
- No state changes on idle cycles.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle response latency, out_ready=1 → addresses 0,4,8,…; first out_valid 2 cycles after first acceptance with out_pc=0, out_pc_plus4=4; then one instruction per cycle in order.
- out_ready=0 with 1-cycle latency, DEPTH=4 → exactly 4 requests accepted, imem_req_valid drops, out_count=4. Raising out_ready resumes issue only after the first pop.
- Latency 3 with 3 requests in flight, redirect to 0x104 → next request addr 0x104 one cycle later. The 3 stale responses are discarded, first out_pc=0x104, out_count=0 the cycle after redirect.
- Redirect coincides with a response, a pop, and imem_req_ready=1 → no request issued, the response is not enqueued, drop = outstanding-1, queue empty.
- fetch_pc=0xFFFFFFFC (XLEN=32) accepted → next addr 0x0; the queued entry has out_pc_plus4=0x0.
- Synchronous reset asserted mid-stream with redirect_valid=1 → next cycle fetch_pc=RESET_PC, out_valid=0, imem_req_valid=0 while reset is high; the redirect is ignored.
